ps2_keyboard_tx: RTL

PS2_KEYBOARD_TX -- requirements
Module: ps2_keyboard_tx

---
 rtl/ps2_pkg.sv | 11 +
 rtl/ps2_fifo.sv | 39 +++
 rtl/ps2_keyboard_tx.sv | 111 +++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared FSM states, frame size and frame-building helpers for the PS/2 transmitter
package ps2_pkg;
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
    localparam int FRAME_BITS = 11;
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction
    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] d);
        return {1'b1, odd_parity(d), d, 1'b0};
    endfunction
endpackage

// File: rtl/ps2_fifo.sv
// ps2_fifo: synchronous scancode FIFO with registered occupancy count
module ps2_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [7:0]               wdata,
    input  logic                     pop,
    output logic [7:0]               rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;
    assign full    = count == FULL_CNT;
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/ps2_keyboard_tx.sv
// ps2_keyboard_tx: device-side PS/2 transmitter; buffers scancodes and sends 11-bit odd-parity frames
module ps2_keyboard_tx #(
    parameter int CLK_DIV    = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_CYC    = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          ps2_clk,
    output logic                          ps2_data,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    import ps2_pkg::*;
    localparam int CW = $clog2((CLK_DIV > GAP_CYC ? CLK_DIV : GAP_CYC) + 1);
    localparam logic [CW-1:0] DIV_END = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_END = CW'(GAP_CYC - 1);
    localparam logic [4:0] LAST_HALF = 5'(2 * FRAME_BITS - 1);
    state_t                  state, state_d;
    logic [CW-1:0]           div_q, div_d;
    logic [4:0]              half_q, half_d;
    logic [FRAME_BITS-2:0]   bits_q, bits_d;
    logic                    clk_q, clk_d, dat_q, dat_d;
    logic                    rdy_en, push, pop, full, empty;
    logic [7:0]              head;
    logic [FRAME_BITS-1:0]   frame;
    ps2_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .wdata  (in_data),
        .pop    (pop),
        .rdata  (head),
        .count  (fifo_count),
        .full   (full),
        .empty  (empty)
    );
    // rdy_en keeps in_ready low until the first edge after reset release
    assign in_ready = rdy_en && !full;
    assign push     = in_valid && in_ready;
    assign busy     = state != IDLE || !empty;
    assign frame    = make_frame(head);
    assign ps2_clk  = clk_q;
    assign ps2_data = dat_q;
    always_comb begin
        state_d = state;
        div_d   = div_q;
        half_d  = half_q;
        bits_d  = bits_q;
        clk_d   = clk_q;
        dat_d   = dat_q;
        pop     = 1'b0;
        case (state)
            IDLE: if (!empty) begin
                pop     = 1'b1;
                state_d = SEND;
                dat_d   = frame[0];
                bits_d  = frame[FRAME_BITS-1:1];
                div_d   = '0;
                half_d  = '0;
            end
            SEND: if (div_q != DIV_END) begin
                div_d = div_q + 1'b1;
            end else begin
                div_d  = '0;
                half_d = half_q + 5'd1;
                // even half index = high half ending, odd = low half ending (next bit starts)
                if (half_q == LAST_HALF) begin
                    state_d = GAP;
                    clk_d   = 1'b1;
                    dat_d   = 1'b1;
                end else if (!half_q[0]) begin
                    clk_d = 1'b0;
                end else begin
                    clk_d  = 1'b1;
                    dat_d  = bits_q[0];
                    bits_d = bits_q >> 1;
                end
            end
            GAP: if (div_q != GAP_END) begin
                div_d = div_q + 1'b1;
            end else begin
                div_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            div_q  <= '0;
            half_q <= '0;
            bits_q <= '0;
            clk_q  <= 1'b1;
            dat_q  <= 1'b1;
            rdy_en <= 1'b0;
        end else begin
            state  <= state_d;
            div_q  <= div_d;
            half_q <= half_d;
            bits_q <= bits_d;
            clk_q  <= clk_d;
            dat_q  <= dat_d;
            rdy_en <= 1'b1;
        end
    end
endmodule
